// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to LO, remainder to HI.
// One restoring step per cycle, sign fix-up in a final cycle; zero divisor aborts with a divzero pulse.
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             div_start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] lo_out,
    output logic [WIDTH-1:0] hi_out,
    output logic             div_busy,
    output logic             div_done,
    output logic             divzero
);

    localparam int unsigned CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [CW-1:0]    r_count;
    logic             r_dsign;
    logic             r_qsign;

    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_trial;
    logic             w_step_ok;

    // Unsigned magnitudes; -2^(WIDTH-1) maps exactly onto 2^(WIDTH-1).
    assign w_abs_a   = dividend[WIDTH-1] ? WIDTH'(-dividend) : dividend;
    assign w_abs_b   = divisor[WIDTH-1]  ? WIDTH'(-divisor)  : divisor;

    // Partial remainder stays below the divisor, so the shifted value needs one extra bit.
    assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_rem_sh - {1'b0, r_dvs};
    assign w_step_ok = ~w_trial[WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_count  <= '0;
            r_dsign  <= 1'b0;
            r_qsign  <= 1'b0;
            lo_out   <= '0;
            hi_out   <= '0;
            div_busy <= 1'b0;
            div_done <= 1'b0;
            divzero  <= 1'b0;
        end else begin
            div_done <= 1'b0;
            divzero  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    div_busy <= 1'b0;
                    if (div_start) begin
                        if (divisor == '0) begin
                            divzero <= 1'b1;
                        end else begin
                            r_quo    <= w_abs_a;
                            r_dvs    <= w_abs_b;
                            r_rem    <= '0;
                            r_dsign  <= dividend[WIDTH-1];
                            r_qsign  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            r_count  <= '0;
                            div_busy <= 1'b1;
                            r_state  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_quo   <= {r_quo[WIDTH-2:0], w_step_ok};
                    r_rem   <= w_step_ok ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    lo_out   <= r_qsign ? WIDTH'(-r_quo) : r_quo;
                    hi_out   <= r_dsign ? WIDTH'(-r_rem) : r_rem;
                    div_done <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: cycle-level reference model plus directed and random operations.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        div_start = 1'b0;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic [31:0] lo_out;
    logic [31:0] hi_out;
    logic        div_busy;
    logic        div_done;
    logic        divzero;

    int checks = 0;
    int failures = 0;
    int done_count = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .div_start (div_start),
        .dividend  (dividend),
        .divisor   (divisor),
        .lo_out    (lo_out),
        .hi_out    (hi_out),
        .div_busy  (div_busy),
        .div_done  (div_done),
        .divzero   (divzero)
    );

    always #5 clk = ~clk;

    // Reference: {quotient, remainder} with truncation toward zero, remainder signed like dividend.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {q[31:0], r[31:0]};
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endfunction

    // Cycle model: an accepted operation completes a fixed 33 edges after its start edge.
    int          m_cnt = 0;
    logic [31:0] m_q = 32'd0;
    logic [31:0] m_r = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [31:0] m_hi = 32'd0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    logic [63:0] m_res;

    always @(posedge clk) begin
        if (!reset) begin
            m_cnt  <= 0;
            m_lo   <= 32'd0;
            m_hi   <= 32'd0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dz   <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_dz   <= 1'b0;
            if (m_cnt == 0) begin
                if (div_start && divisor == 32'd0) begin
                    m_dz   <= 1'b1;
                    m_busy <= 1'b0;
                end else if (div_start) begin
                    m_res  = ref_div(dividend, divisor);
                    m_q    <= m_res[63:32];
                    m_r    <= m_res[31:0];
                    m_cnt  <= 33;
                    m_busy <= 1'b1;
                end else begin
                    m_busy <= 1'b0;
                end
            end else begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_lo   <= m_q;
                    m_hi   <= m_r;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_lo", lo_out, m_lo);
        chk("cyc_hi", hi_out, m_hi);
        chk("cyc_busy", 32'(div_busy), 32'(m_busy));
        chk("cyc_done", 32'(div_done), 32'(m_done));
        chk("cyc_divzero", 32'(divzero), 32'(m_dz));
        if (div_done === 1'b1) done_count++;
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        dividend  = a;
        divisor   = b;
        div_start = 1'b1;
        @(negedge clk);
        div_start = 1'b0;
    endtask

    // Returns at the negedge where done or divzero is high; k counts negedges since the start edge.
    task automatic wait_ev(output int k);
        k = 1;
        while (!(div_done === 1'b1 || divzero === 1'b1) && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (k >= 60) begin
            checks++;
            failures++;
            $display("FAIL wait_timeout actual=%0d cycles required=done or divzero", k);
        end
    endtask

    task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er);
        int k;
        @(negedge clk);
        start_op(a, b);
        wait_ev(k);
        chk({name, "_lat"}, 32'(k), 32'd34);
        chk({name, "_lo"}, lo_out, eq);
        chk({name, "_hi"}, hi_out, er);
    endtask

    logic [63:0] pin;
    logic [31:0] ra;
    logic [31:0] rb;
    int          kk;
    int          dc0;

    initial begin
        pin = ref_div(32'hFFFF_FFF9, 32'd2);
        chk("pin_m7_2_q", pin[63:32], 32'hFFFF_FFFD);
        chk("pin_m7_2_r", pin[31:0], 32'hFFFF_FFFF);
        pin = ref_div(32'h8000_0000, 32'hFFFF_FFFF);
        chk("pin_min_m1_q", pin[63:32], 32'h8000_0000);
        chk("pin_min_m1_r", pin[31:0], 32'd0);
        pin = ref_div(32'd7, 32'hFFFF_FFFE);
        chk("pin_7_m2_r", pin[31:0], 32'd1);

        repeat (2) @(negedge clk);
        chk("rst_lo", lo_out, 32'd0);
        chk("rst_hi", hi_out, 32'd0);
        chk("rst_busy", 32'(div_busy), 32'd0);
        reset = 1'b1;

        do_op("basic", 32'd7, 32'd2, 32'd3, 32'd1);
        do_op("neg_pos", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_op("pos_neg", 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        do_op("neg_neg", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF);
        do_op("basic2", 32'd7, 32'd2, 32'd3, 32'd1);

        // Divide by zero leaves results untouched.
        @(negedge clk);
        dc0 = done_count;
        start_op(32'd5, 32'd0);
        chk("dz_pulse", 32'(divzero), 32'd1);
        chk("dz_busy", 32'(div_busy), 32'd0);
        chk("dz_lo", lo_out, 32'd3);
        chk("dz_hi", hi_out, 32'd1);
        @(negedge clk);
        chk("dz_one_cycle", 32'(divzero), 32'd0);
        repeat (40) @(negedge clk);
        chk("dz_no_done", 32'(done_count), 32'(dc0));

        do_op("min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        do_op("max_1", 32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0);
        do_op("small", 32'd3, 32'd10, 32'd0, 32'd3);

        // A start while busy is ignored.
        @(negedge clk);
        dc0 = done_count;
        start_op(32'd100, 32'd7);
        repeat (8) @(negedge clk);
        start_op(32'd9, 32'd3);
        wait_ev(kk);
        chk("busy_lo", lo_out, 32'd14);
        chk("busy_hi", hi_out, 32'd2);
        repeat (40) @(negedge clk);
        chk("busy_one_done", 32'(done_count), 32'(dc0 + 1));

        // Reset mid-operation abandons it.
        dc0 = done_count;
        start_op(32'd50, 32'd3);
        repeat (13) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_lo", lo_out, 32'd0);
        chk("mrst_hi", hi_out, 32'd0);
        chk("mrst_busy", 32'(div_busy), 32'd0);
        repeat (40) @(negedge clk);
        chk("mrst_no_done", 32'(done_count), 32'(dc0));

        // Back-to-back: second start in the cycle done is high.
        start_op(32'd20, 32'd6);
        wait_ev(kk);
        start_op(32'd9, 32'd3);
        wait_ev(kk);
        chk("b2b_lat", 32'(kk), 32'd34);
        chk("b2b_lo", lo_out, 32'd3);
        chk("b2b_hi", hi_out, 32'd0);

        for (int i = 0; i < 1000; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($signed(16'($urandom)));
                2: ra = 32'($signed(8'($urandom)));
                3: rb = 32'($signed(4'($urandom)));
                default: ;
            endcase
            repeat ($urandom_range(0, 2)) @(negedge clk);
            start_op(ra, rb);
            dividend = $urandom;
            divisor  = $urandom;
            wait_ev(kk);
            if (rb != 32'd0) begin
                pin = ref_div(ra, rb);
                chk("rnd_lo", lo_out, pin[63:32]);
                chk("rnd_hi", hi_out, pin[31:0]);
            end
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
